// File: rtl/fmul_share_arb.sv
// Round-robin arbiter that shares one combinational fmul between NREQ requesters.
// Two register stages: the operand register feeds fmul, and the result register holds its output.
module fmul_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_x1,
   input  logic [32*NREQ-1:0]   req_x2,
   output logic [31:0]          fmul_x1,
   output logic [31:0]          fmul_x2,
   input  logic [31:0]          fmul_y,
   input  logic                 fmul_exception,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [31:0]          resp_y,
   output logic                 resp_exception
);

   logic            op_v_q, op_v_d;
   logic [IDW-1:0]  op_id_q, op_id_d;
   logic [31:0]     op_x1_q, op_x1_d;
   logic [31:0]     op_x2_q, op_x2_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic            resp_valid_q, resp_valid_d;
   logic [IDW-1:0]  resp_id_q, resp_id_d;
   logic [31:0]     resp_y_q, resp_y_d;
   logic            resp_exc_q, resp_exc_d;

   logic            s2_free, s1_adv, s1_free, hs;
   logic            gnt_found;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW:0]    cand;

   assign s2_free = ~resp_valid_q | resp_ready;
   assign s1_adv  = op_v_q & s2_free;
   assign s1_free = ~op_v_q | s1_adv;

   // Scan from the pointer with wrap-around; cand stays below 2*NREQ so a single subtract suffices.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   // Grant is masked during reset so no requester sees a handshake it will lose.
   assign hs = gnt_found & s1_free & ~rst;

   always_comb begin
      req_ready = '0;
      if (hs) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      op_v_d       = op_v_q;
      op_id_d      = op_id_q;
      op_x1_d      = op_x1_q;
      op_x2_d      = op_x2_q;
      ptr_d        = ptr_q;
      resp_valid_d = resp_valid_q;
      resp_id_d    = resp_id_q;
      resp_y_d     = resp_y_q;
      resp_exc_d   = resp_exc_q;

      if (hs) begin
         op_v_d  = 1'b1;
         op_id_d = gnt_idx;
         op_x1_d = req_x1[32*gnt_idx +: 32];
         op_x2_d = req_x2[32*gnt_idx +: 32];
         ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (s1_adv) begin
         op_v_d = 1'b0;
      end

      if (s1_adv) begin
         resp_valid_d = 1'b1;
         resp_id_d    = op_id_q;
         resp_y_d     = fmul_y;
         resp_exc_d   = fmul_exception;
      end else if (resp_valid_q && resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   // Operands only load on a handshake, so the fmul inputs stay quiet while S1 is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_v_q       <= 1'b0;
         op_id_q      <= '0;
         op_x1_q      <= '0;
         op_x2_q      <= '0;
         ptr_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_y_q     <= '0;
         resp_exc_q   <= 1'b0;
      end else begin
         op_v_q       <= op_v_d;
         op_id_q      <= op_id_d;
         op_x1_q      <= op_x1_d;
         op_x2_q      <= op_x2_d;
         ptr_q        <= ptr_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_y_q     <= resp_y_d;
         resp_exc_q   <= resp_exc_d;
      end
   end

   assign fmul_x1        = op_x1_q;
   assign fmul_x2        = op_x2_q;
   assign resp_valid     = resp_valid_q;
   assign resp_id        = resp_id_q;
   assign resp_y         = resp_y_q;
   assign resp_exception = resp_exc_q;

endmodule

// File: tb/tb_fmul_share_arb.sv
// Self-checking bench for fmul_share_arb: stand-in fmul, queue-based reference model, directed and random scenarios.
module tb_fmul_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid, req_ready;
   logic [32*NREQ-1:0]  req_x1, req_x2;
   logic [31:0]         fmul_x1, fmul_x2, fmul_y;
   logic                fmul_exception;
   logic                resp_valid, resp_ready;
   logic [IDW-1:0]      resp_id;
   logic [31:0]         resp_y;
   logic                resp_exception;

   always #5 clk = ~clk;

   fmul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x1(req_x1), .req_x2(req_x2),
      .fmul_x1(fmul_x1), .fmul_x2(fmul_x2),
      .fmul_y(fmul_y), .fmul_exception(fmul_exception),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_y(resp_y), .resp_exception(resp_exception)
   );

   // Stand-in fmul: exact for the directed vectors, an arbitrary hash elsewhere.
   function automatic logic [32:0] fake_fmul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
      if (a == 32'h7F000000 && b == 32'h7F000000) return {1'b1, 32'h7F800000};
      return {^(a ^ b), (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]}};
   endfunction

   always_comb {fmul_exception, fmul_y} = fake_fmul(fmul_x1, fmul_x2);

   typedef struct {
      logic [IDW-1:0] id;
      logic [31:0]    x1;
      logic [31:0]    x2;
      bit             done;
   } item_t;

   int          checks = 0;
   int          errors = 0;
   item_t       q[$];
   int          ptr = 0;
   int          last_grant = -1;
   logic [31:0] ax1 [NREQ];
   logic [31:0] ax2 [NREQ];

   // One clock of stimulus plus model comparison; entered and left at a negedge.
   task automatic step(input logic [NREQ-1:0] v, input logic rr);
      logic [NREQ-1:0] exp_rdy;
      logic [32:0]     exp_res;
      bit              has_out, has_mid, s2f, acc;
      int              g;
      item_t           it;
      req_valid  = v;
      resp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         req_x1[32*i +: 32] = ax1[i];
         req_x2[32*i +: 32] = ax2[i];
      end
      has_out = (q.size() > 0) && q[0].done;
      has_mid = (q.size() > 0) && !q[q.size()-1].done;
      s2f     = !has_out || rr;
      acc     = !has_mid || s2f;
      g = -1;
      if (acc)
         for (int k = 0; k < NREQ; k++)
            if (g < 0 && v[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL req_ready got %b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (resp_valid !== has_out) begin
         errors++;
         $display("FAIL resp_valid got %b expected %b", resp_valid, has_out);
      end
      if (has_out) begin
         exp_res = fake_fmul(q[0].x1, q[0].x2);
         checks++;
         if ({resp_id, resp_exception, resp_y} !== {q[0].id, exp_res}) begin
            errors++;
            $display("FAIL resp_data got id=%0d exc=%b y=%h expected id=%0d exc=%b y=%h",
                     resp_id, resp_exception, resp_y, q[0].id, exp_res[32], exp_res[31:0]);
         end
      end
      @(posedge clk);
      if (has_out && rr) void'(q.pop_front());
      if (has_mid && s2f) q[q.size()-1].done = 1'b1;
      last_grant = g;
      if (g >= 0) begin
         it.id = IDW'(g); it.x1 = ax1[g]; it.x2 = ax2[g]; it.done = 1'b0;
         q.push_back(it);
         ptr = (g + 1) % NREQ;
         ax1[g] = $urandom;
         ax2[g] = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      ptr = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && q.size() > 0; k++) step('0, 1'b1);
      checks++;
      if (q.size() != 0 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain got resp_valid=%b pending=%0d expected 0 and 0", resp_valid, q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      resp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++;
      if ({resp_valid, resp_id, resp_y, resp_exception, req_ready, fmul_x1, fmul_x2} !== '0) begin
         errors++;
         $display("FAIL reset_state got rv=%b id=%0d y=%h exc=%b rdy=%b x1=%h x2=%h expected all 0",
                  resp_valid, resp_id, resp_y, resp_exception, req_ready, fmul_x1, fmul_x2);
      end
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      q.delete();
      ptr = 0;
   endtask

   task automatic test_single();
      ax1[0] = 32'h40000000; ax2[0] = 32'h40400000;
      step(4'b0001, 1'b1);
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early got resp_valid=%b expected 0", resp_valid);
      end
      step(4'b0000, 1'b1);
      checks++;
      if ({resp_valid, resp_y, resp_exception, resp_id} !== {1'b1, 32'h40C00000, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL single_op got rv=%b y=%h exc=%b id=%0d expected rv=1 y=40c00000 exc=0 id=0",
                  resp_valid, resp_y, resp_exception, resp_id);
      end
      drain();
   endtask

   task automatic test_overflow();
      ax1[2] = 32'h7F000000; ax2[2] = 32'h7F000000;
      step(4'b0100, 1'b1);
      step(4'b0000, 1'b1);
      checks++;
      if ({resp_valid, resp_y, resp_exception, resp_id} !== {1'b1, 32'h7F800000, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL overflow got rv=%b y=%h exc=%b id=%0d expected rv=1 y=7f800000 exc=1 id=2",
                  resp_valid, resp_y, resp_exception, resp_id);
      end
      drain();
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int k = 0; k < 12; k++) begin
         step(4'b1111, 1'b1);
         checks++;
         if (last_grant != k % NREQ) begin
            errors++;
            $display("FAIL rr_order got %0d expected %0d", last_grant, k % NREQ);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      int grants = 0;
      for (int k = 0; k < 5; k++) begin
         step(4'b1111, 1'b0);
         if (last_grant >= 0) grants++;
      end
      checks++;
      if (grants != 2) begin
         errors++;
         $display("FAIL bp_grants got %0d expected 2", grants);
      end
      for (int k = 0; k < 6; k++) step(4'b1111, 1'b1);
      drain();
   endtask

   task automatic test_fairness();
      int exp_seq [4] = '{3, 1, -1, 3};
      apply_reset();
      step(4'b0010, 1'b1);
      step(4'b1010, 1'b1);
      checks++;
      if (last_grant != exp_seq[0]) begin
         errors++;
         $display("FAIL fair_a got %0d expected %0d", last_grant, exp_seq[0]);
      end
      step(4'b1010, 1'b1);
      checks++;
      if (last_grant != exp_seq[1]) begin
         errors++;
         $display("FAIL fair_b got %0d expected %0d", last_grant, exp_seq[1]);
      end
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      step(4'b1010, 1'b1);
      checks++;
      if (last_grant != exp_seq[3]) begin
         errors++;
         $display("FAIL fair_idle got %0d expected %0d", last_grant, exp_seq[3]);
      end
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++)
         step(NREQ'($urandom), ($urandom_range(0, 3) != 0));
      drain();
   endtask

   task automatic test_reset_midflight();
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({resp_valid, req_ready, resp_y} !== '0) begin
         errors++;
         $display("FAIL midreset got rv=%b rdy=%b y=%h expected 0 0 0", resp_valid, req_ready, resp_y);
      end
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      ptr = 0;
      step(4'b1010, 1'b1);
      checks++;
      if (last_grant != 1) begin
         errors++;
         $display("FAIL post_reset_grant got %0d expected 1", last_grant);
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         ax1[i] = $urandom;
         ax2[i] = $urandom;
      end
      req_x1 = '0;
      req_x2 = '0;
      test_reset();
      @(negedge clk);
      test_single();
      test_overflow();
      test_round_robin();
      test_backpressure();
      test_fairness();
      test_random();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
